// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: shared widths, PLAN segment constants and helpers for the
// sigmoid evaluator.
// Configuration macro: SIGMOID_EXTRA_PIPE_EN (adds a third pipeline stage, LAT = 3).
package sigmoid_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 16;
    localparam int A_W = 8;

    // Segment breakpoints on |x| in 1/32 units
    localparam logic [A_W-1:0] BRK0 = 8'd32;
    localparam logic [A_W-1:0] BRK1 = 8'd76;

    // Segment offsets (y*65536) and slope shifts
    localparam logic [Y_W-1:0] OFF0 = 16'd32768;
    localparam logic [Y_W-1:0] OFF1 = 16'd40960;
    localparam logic [Y_W-1:0] OFF2 = 16'd55296;
    localparam int SH0 = 9;
    localparam int SH1 = 8;
    localparam int SH2 = 6;

`ifdef SIGMOID_EXTRA_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef enum logic [1:0] {
        SEG_LO  = 2'd0,
        SEG_MID = 2'd1,
        SEG_HI  = 2'd2
    } seg_e;

    // Select the PLAN segment for a magnitude a
    function automatic seg_e seg_of(input logic [A_W-1:0] a);
        seg_e seg;
        if (a < BRK0) begin
            seg = SEG_LO;
        end else if (a < BRK1) begin
            seg = SEG_MID;
        end else begin
            seg = SEG_HI;
        end
        return seg;
    endfunction

    // Magnitude of a Q3.5 code; -128 maps to 128, which still fits 8 bits
    function automatic logic [A_W-1:0] abs_x(input logic [X_W-1:0] x);
        logic [A_W-1:0] a;
        if (x[X_W-1]) begin
            a = A_W'(~x + 8'd1);
        end else begin
            a = x;
        end
        return a;
    endfunction

endpackage

// File: rtl/sigmoid_plan_core.sv
// sigmoid_plan_core: combinational PLAN evaluator, split into two halves so
// the top may place a register between them.
//   a, seg  -> p      : positive-half value p(a) = offset + (a << shift)
//   s, p_in -> y      : mirror about 0.5 for negative x (y = 65536 - p)
// Shift-add only; no multipliers.
module sigmoid_plan_core
    import sigmoid_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  seg_e           seg,
    output logic [Y_W-1:0] p,
    input  logic           s,
    input  logic [Y_W-1:0] p_in,
    output logic [Y_W-1:0] y
);

    // Segment offset plus shifted magnitude
    always_comb begin
        p = OFF0;
        case (seg)
            SEG_LO:  p = OFF0 + (Y_W'(a) << SH0);
            SEG_MID: p = OFF1 + (Y_W'(a) << SH1);
            SEG_HI:  p = OFF2 + (Y_W'(a) << SH2);
            default: p = OFF0;
        endcase
    end

    // p_in >= 32768 always, so 65536 - p_in fits in 16 bits
    always_comb begin
        y = p_in;
        if (s) begin
            y = Y_W'(17'h10000 - {1'b0, p_in});
        end else begin
            y = p_in;
        end
    end

endmodule

// File: rtl/sigmoid.sv
// sigmoid: streaming fixed-point logistic function, one sample per clock.
// Configuration macro: SIGMOID_EXTRA_PIPE_EN (register between segment add
// and complement, LAT = 3; default LAT = 2).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_x          signed Q3.5 input sample
//   i_in_valid   i_x valid this cycle
//   o_out_valid  o_y valid this cycle
//   o_y          unsigned Q0.16 result, holds while o_out_valid is low
//   number       constant NUM_TRANSISTORS
module sigmoid
    import sigmoid_pkg::*;
#(
    parameter logic [50:0] NUM_TRANSISTORS = 51'd2000
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] i_x,
    input  logic           i_in_valid,
    output logic           o_out_valid,
    output logic [Y_W-1:0] o_y,
    output logic [50:0]    number
);

    logic [LAT-1:0] valid_r;
    logic           s1_s_r;
    logic [A_W-1:0] s1_a_r;
    seg_e           s1_seg_r;
    logic [Y_W-1:0] p_s;
    logic [Y_W-1:0] y_s;
    logic [Y_W-1:0] o_y_r;
    logic           cmp_s_s;
    logic [Y_W-1:0] cmp_p_s;

    assign number      = NUM_TRANSISTORS;
    assign o_out_valid = valid_r[LAT-1];
    assign o_y         = o_y_r;

    // Valid shift pipe; bubbles propagate unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else begin
            valid_r <= {valid_r[LAT-2:0], i_in_valid};
        end
    end

    // Stage 1: sign, magnitude and segment, loaded only on valid input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_s_r   <= 1'b0;
            s1_a_r   <= 8'd0;
            s1_seg_r <= SEG_LO;
        end else if (i_in_valid) begin
            s1_s_r   <= i_x[X_W-1];
            s1_a_r   <= abs_x(i_x);
            s1_seg_r <= seg_of(abs_x(i_x));
        end
    end

    sigmoid_plan_core u_core (
        .a    (s1_a_r),
        .seg  (s1_seg_r),
        .p    (p_s),
        .s    (cmp_s_s),
        .p_in (cmp_p_s),
        .y    (y_s)
    );

`ifdef SIGMOID_EXTRA_PIPE_EN
    logic           s2_s_r;
    logic [Y_W-1:0] s2_p_r;

    // Extra stage: hold segment sum and sign ahead of the complement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_s_r <= 1'b0;
            s2_p_r <= 16'd0;
        end else if (valid_r[0]) begin
            s2_s_r <= s1_s_r;
            s2_p_r <= p_s;
        end
    end

    assign cmp_s_s = s2_s_r;
    assign cmp_p_s = s2_p_r;
`else
    assign cmp_s_s = s1_s_r;
    assign cmp_p_s = p_s;
`endif

    // Output register, loads only when the final stage carries a valid sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_y_r <= 16'd0;
        end else if (valid_r[LAT-2]) begin
            o_y_r <= y_s;
        end
    end

endmodule

// File: tb/tb_sigmoid.sv
// tb_sigmoid: randomized and directed self-checking bench for sigmoid.
// Reference: piecewise-linear formula in plain integer arithmetic plus the
// ideal logistic function, delayed by the expected latency.
module tb_sigmoid;

`ifdef SIGMOID_EXTRA_PIPE_EN
    localparam int LAT_TB = 3;
`else
    localparam int LAT_TB = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_x;
    logic        i_in_valid;
    logic        o_out_valid;
    logic [15:0] o_y;
    logic [50:0] number;

    int tests_run;
    int tests_failed;
    bit mon_en;
    int run_len;
    int last_run;

    sigmoid dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_x         (i_x),
        .i_in_valid  (i_in_valid),
        .o_out_valid (o_out_valid),
        .o_y         (o_y),
        .number      (number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_y(input logic [7:0] x);
        int xi;
        int a;
        int p;
        xi = int'($signed(x));
        a  = (xi < 0) ? -xi : xi;
        if (a < 32)      p = 32768 + 512 * a;
        else if (a < 76) p = 40960 + 256 * a;
        else             p = 55296 + 64 * a;
        return (xi < 0) ? 65536 - p : p;
    endfunction

    function automatic real ideal_y(input logic [7:0] x);
        real xr;
        xr = real'(int'($signed(x))) / 32.0;
        return 65536.0 / (1.0 + $exp(-xr));
    endfunction

    // Expected-output delay line
    logic mv [0:2];
    int   my [0:2];
    real  mi [0:2];
    logic m_v;
    int   m_y;
    real  m_i;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] <= 1'b0;
                my[i] <= 0;
                mi[i] <= 0.0;
            end
            m_v <= 1'b0;
            m_y <= 0;
            m_i <= 0.0;
        end else begin
            mv[0] <= i_in_valid;
            my[0] <= i_in_valid ? ref_y(i_x) : 0;
            mi[0] <= i_in_valid ? ideal_y(i_x) : 0.0;
            for (int i = 1; i < 3; i++) begin
                mv[i] <= mv[i-1];
                my[i] <= my[i-1];
                mi[i] <= mi[i-1];
            end
            m_v <= mv[LAT_TB-2];
            if (mv[LAT_TB-2]) begin
                m_y <= my[LAT_TB-2];
                m_i <= mi[LAT_TB-2];
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid", longint'(o_out_valid), longint'(m_v));
            check("y", longint'(o_y), longint'(m_y));
            if (o_out_valid && m_v) begin
                check("ideal_err_le_1400",
                      longint'(((real'(o_y) - m_i) <= 1400.0) && ((m_i - real'(o_y)) <= 1400.0)),
                      64'sd1);
            end
        end
        if (!rst_n) begin
            run_len = 0;
        end else if (o_out_valid) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic drive(input logic v, input logic [7:0] x);
        @(posedge clk);
        #1;
        i_in_valid = v;
        i_x        = x;
    endtask

    // Single sample; result must appear exactly LAT edges after the capture edge
    task automatic send1(input string tag, input logic [7:0] x, input int exp);
        drive(1'b1, x);
        drive(1'b0, 8'h00);
        check({tag, "_early"}, longint'(o_out_valid), 64'sd0);
        repeat (LAT_TB - 1) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_valid"}, longint'(o_out_valid), 64'sd1);
        check(tag, longint'(o_y), longint'(exp));
        drive(1'b0, 8'h00);
        check({tag, "_hold"}, longint'(o_y), longint'(exp));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mon_en       = 1'b0;
        run_len      = 0;
        last_run     = 0;
        rst_n        = 1'b0;
        i_in_valid   = 1'b0;
        i_x          = 8'h00;
        #12;
        check("reset_valid", longint'(o_out_valid), 64'sd0);
        check("reset_y", longint'(o_y), 64'sd0);
        check("number", longint'(number), 64'sd2000);
        @(negedge clk);
        rst_n = 1'b1;

        send1("x00", 8'h00, 32768);
        send1("x20", 8'h20, 49152);
        send1("xE0", 8'hE0, 16384);
        send1("x7F", 8'h7F, 63424);
        send1("x80", 8'h80, 2048);
        send1("x4C", 8'h4C, 60160);
        send1("x4B", 8'h4B, 60160);
        send1("x1F", 8'h1F, 48640);

        mon_en = 1'b1;
        // All 256 codes back-to-back
        for (int c = 0; c < 256; c++) begin
            drive(1'b1, 8'(c));
        end
        drive(1'b0, 8'h00);
        repeat (LAT_TB + 2) drive(1'b0, 8'h00);
        check("stream_run_len", longint'(last_run), 64'sd256);

        // Bubble pattern with random data, idle data left unknown
        for (int r = 0; r < 4; r++) begin
            drive(1'b1, 8'($urandom_range(0, 255)));
            drive(1'b0, 8'bxxxx_xxxx);
            drive(1'b1, 8'($urandom_range(0, 255)));
            drive(1'b1, 8'($urandom_range(0, 255)));
            drive(1'b0, 8'bxxxx_xxxx);
        end
        repeat (LAT_TB + 1) drive(1'b0, 8'h00);

        // Random valid density
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
        end
        repeat (LAT_TB + 1) drive(1'b0, 8'h00);

        // Asynchronous reset mid-stream
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 8'($urandom_range(0, 255)));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", longint'(o_out_valid), 64'sd0);
        check("async_rst_y", longint'(o_y), 64'sd0);
        i_in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 8'h00);
        check("post_rst_y_zero", longint'(o_y), 64'sd0);
        for (int n = 0; n < 40; n++) begin
            drive(1'b1, 8'($urandom_range(0, 255)));
        end
        repeat (LAT_TB + 1) drive(1'b0, 8'h00);
        mon_en = 1'b0;

        send1("restart_x20", 8'h20, 49152);
        check("number_end", longint'(number), 64'sd2000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
